// File: rtl/mux41_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux41_rr_arbiter_pkg
// Shared definitions for the round-robin 4:1 mux arbiter slice.
//   NREQ             : number of requesters sharing the mux
//   state_e          : arbiter FSM states (IDLE = no grant, GRANT = one owner)
//   DEFAULT_MAX_HOLD : default bound on consecutive grant cycles under contention
//   DEFAULT_CW       : default width of the hold counter
//   onehot4()        : converts a 2-bit source index into a one-hot grant vector
// ---------------------------------------------------------------------------
package mux41_rr_arbiter_pkg;

  localparam int NREQ             = 4;
  localparam int DEFAULT_MAX_HOLD = 8;
  localparam int DEFAULT_CW       = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Decodes a source index into the one-hot form used by gnt and by the
  // "mask out the current owner" step of the release pick.
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux41_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// mux41_rr_arbiter_if
// Bundles the requester-side signals of the shared 4:1 mux.
//   req  : request per source (req[i] = source i wants the mux)
//   w    : mux data inputs w[3:0]
//   gnt  : one-hot grant, zero when idle
//   sel  : mux select {s1,s0}, index of the granted source
//   f    : registered mux output
//   busy : high while a grant is active
// Modports:
//   master : the requesters (drive req/w, observe the arbiter outputs)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface mux41_rr_arbiter_if;
  import mux41_rr_arbiter_pkg::*;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] w;
  logic [NREQ-1:0] gnt;
  logic [1:0]      sel;
  logic            f;
  logic            busy;

  modport master (
    output req,
    output w,
    input  gnt,
    input  sel,
    input  f,
    input  busy
  );

  modport slave (
    input  req,
    input  w,
    output gnt,
    output sel,
    output f,
    output busy
  );

endinterface

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker over four requests.
//   req_i   : raw request vector
//   mask_i  : bits to ignore (the current owner during a release pick)
//   ptr_i   : first index to consider; search order is ptr, ptr+1, ... mod 4
//   idx_o   : index of the first unmasked request found in that order
//   found_o : high when any unmasked request exists (idx_o is 0 otherwise)
// ---------------------------------------------------------------------------
module rr_pick4
  import mux41_rr_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] mask_i,
  input  logic [1:0]      ptr_i,
  output logic [1:0]      idx_o,
  output logic            found_o
);

  logic [NREQ-1:0] cand;
  logic [1:0]      pos;

  // Walk the four positions starting at the pointer; the 2-bit add wraps
  // naturally, so position 3 is followed by position 0. The first hit wins
  // and later hits are ignored via the found flag.
  always_comb begin
    cand    = req_i & ~mask_i;
    idx_o   = 2'd0;
    found_o = 1'b0;
    pos     = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      pos = ptr_i + 2'(k);
      if (!found_o && cand[pos]) begin
        idx_o   = pos;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux41_rr_arbiter
// Round-robin arbiter and sequencer for a shared 4:1 mux. Grants one source
// at a time, drives the select lines and registers the selected data bit.
// A grant is held at most MAX_HOLD cycles while another source is waiting.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of mux41_rr_arbiter_if (req, w in; gnt, sel, f, busy out)
// Parameters:
//   MAX_HOLD : max consecutive grant cycles under contention (1..2^CW-1)
//   CW       : width of the hold counter
// ---------------------------------------------------------------------------
module mux41_rr_arbiter
  import mux41_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int CW       = DEFAULT_CW
)(
  input  logic              clk,
  input  logic              rst_n,
  mux41_rr_arbiter_if.slave bus
);

  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD - 1);

  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [1:0]      sel_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic            f_q;

  logic [NREQ-1:0] selMask;
  logic            othersWaiting;
  logic            keepGrant;
  logic [NREQ-1:0] pickMask;
  logic [1:0]      pickPtr;
  logic [1:0]      pickIdx;
  logic            pickFound;

  // Decide whether the current owner keeps the mux and set up the single
  // shared picker. In IDLE the picker scans all requests from ptr; in GRANT
  // it is pre-armed for a release: owner masked out, scan starting one past
  // the owner, which is also the value ptr takes on release.
  always_comb begin
    selMask       = onehot4(sel_q);
    othersWaiting = |(bus.req & ~selMask);
    keepGrant     = bus.req[sel_q] && (!othersWaiting || (cnt_q < HOLD_LIMIT));
    if (state_q == ST_GRANT) begin
      pickMask = selMask;
      pickPtr  = sel_q + 2'd1;
    end else begin
      pickMask = '0;
      pickPtr  = ptr_q;
    end
  end

  rr_pick4 u_pick (
    .req_i   (bus.req),
    .mask_i  (pickMask),
    .ptr_i   (pickPtr),
    .idx_o   (pickIdx),
    .found_o (pickFound)
  );

  // Arbiter FSM plus the registered mux output. The f register uses the
  // select and busy values that were in place before this edge, so it lags
  // gnt/sel by one cycle. A release with another candidate hands the mux
  // over at the same edge; otherwise the block falls back to IDLE with sel
  // frozen at its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      f_q     <= 1'b0;
    end else begin
      f_q <= (state_q == ST_GRANT) ? bus.w[sel_q] : 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pickFound) begin
            state_q <= ST_GRANT;
            gnt_q   <= onehot4(pickIdx);
            sel_q   <= pickIdx;
            cnt_q   <= '0;
          end
        end
        ST_GRANT: begin
          if (keepGrant) begin
            if (cnt_q != HOLD_LIMIT) begin
              cnt_q <= cnt_q + CW'(1);
            end
          end else begin
            ptr_q <= pickPtr;
            cnt_q <= '0;
            if (pickFound) begin
              gnt_q <= onehot4(pickIdx);
              sel_q <= pickIdx;
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.f    = f_q;
  assign bus.busy = (state_q == ST_GRANT);

endmodule
